count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_mon_pkg.sv | 27 ++
 rtl/sync_chain.sv | 31 +++
 rtl/count_monitor.sv | 165 ++++++++++++++++
 tb/tb_count_monitor.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_mon_pkg
//  Description : Shared types and constants for the ripple-counter monitor:
//                interrupt handshake state encoding, wrap-counter ceiling
//                and a saturating increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_mon_pkg;

    // Interrupt handshake states
    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,  // no interrupt outstanding
        IRQ_PEND    = 2'd1,  // irq asserted, waiting for acknowledge
        IRQ_RELEASE = 2'd2   // acknowledged, waiting for irq_ack to drop
    } irq_state_t;

    // Ceiling of the accepted-wrap counter
    localparam int unsigned WRAP_CNT_MAX = 255;

    // Increment that sticks at WRAP_CNT_MAX instead of rolling over
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'(WRAP_CNT_MAX)) ? value : value + 8'd1;
    endfunction

endpackage : count_mon_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Single-bit multi-flop synchronizer with asynchronous
//                active-low reset. STAGES must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain, oldest bit on top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : count_monitor
//  Description : Samples an asynchronous ripple-counter value, accepts only
//                values that are stable for two synchronized samples, flags
//                wrap-arounds (with a saturating wrap counter) and raises a
//                level interrupt with acknowledge handshake when an accepted
//                value matches a threshold. Threshold hits that arrive while
//                an interrupt is outstanding set a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             enable,
    input  logic [WIDTH-1:0] threshold,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] cnt_sync,
    output logic             cnt_valid,
    output logic             wrap_pulse,
    output logic [7:0]       wrap_count,
    output logic             irq,
    output logic             overrun
);

    // ------------------------------------------------------------------
    // Synchronizer: one independent chain per counter bit. Bits may land
    // on different cycles; the stability filter below hides that skew.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_s_val;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_sync
            sync_chain #(
                .STAGES (SYNC_STAGES)
            ) u_sync_chain (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (cnt_in[i]),
                .q     (w_s_val[i])
            );
        end
    endgenerate

    logic [WIDTH-1:0] r_s_prev;
    logic [WIDTH-1:0] r_cnt_sync;
    logic             r_cnt_valid;
    logic             r_wrap_pulse;
    logic [7:0]       r_wrap_count;
    logic             r_hit;
    logic             r_overrun;
    irq_state_t       r_state;
    irq_state_t       w_state_next;
    logic             w_overrun_set;

    logic w_stable;
    logic w_accept;
    logic w_is_wrap;
    logic w_is_hit;

    // Keep the previous synchronized sample for the stability test
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_prev <= '0;
        end else begin
            r_s_prev <= w_s_val;
        end
    end

    assign w_stable  = (w_s_val == r_s_prev);
    assign w_accept  = enable && w_stable && (w_s_val != r_cnt_sync);
    assign w_is_wrap = (w_s_val < r_cnt_sync);
    assign w_is_hit  = (w_s_val == threshold);

    // Accept new stable values; wrap and hit pulses line up with cnt_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_sync   <= '0;
            r_cnt_valid  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_wrap_count <= 8'd0;
            r_hit        <= 1'b0;
        end else begin
            r_cnt_valid  <= w_accept;
            r_wrap_pulse <= w_accept && w_is_wrap;
            r_hit        <= w_accept && w_is_hit;
            if (w_accept) begin
                r_cnt_sync <= w_s_val;
                if (w_is_wrap) begin
                    r_wrap_count <= sat_inc(r_wrap_count);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt handshake. The hit pulse is registered with the accepted
    // value, so irq rises one cycle after cnt_sync shows the match.
    // ------------------------------------------------------------------

    // Interrupt state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IRQ_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and overrun detection; hits outside IDLE are never queued
    always_comb begin
        w_state_next  = r_state;
        w_overrun_set = 1'b0;
        case (r_state)
            IRQ_IDLE: begin
                if (r_hit) begin
                    w_state_next = IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                if (r_hit) begin
                    w_overrun_set = 1'b1;
                end
                if (irq_ack) begin
                    w_state_next = IRQ_RELEASE;
                end
            end
            IRQ_RELEASE: begin
                if (r_hit) begin
                    w_overrun_set = 1'b1;
                end
                if (!irq_ack) begin
                    w_state_next = IRQ_IDLE;
                end
            end
            default: begin
                w_state_next = IRQ_IDLE;
            end
        endcase
    end

    // Sticky overrun flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end
    end

    assign cnt_sync   = r_cnt_sync;
    assign cnt_valid  = r_cnt_valid;
    assign wrap_pulse = r_wrap_pulse;
    assign wrap_count = r_wrap_count;
    assign irq        = (r_state == IRQ_PEND);
    assign overrun    = r_overrun;

endmodule : count_monitor
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_monitor
//  Description : Self-checking bench for count_monitor. A history-based
//                reference model predicts every output each cycle; scenario
//                tasks add directed checks on latency, wraps and interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] cnt_in;
    logic             enable;
    logic [WIDTH-1:0] threshold;
    logic             irq_ack;
    logic [WIDTH-1:0] cnt_sync;
    logic             cnt_valid;
    logic             wrap_pulse;
    logic [7:0]       wrap_count;
    logic             irq;
    logic             overrun;

    count_monitor #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_in     (cnt_in),
        .enable     (enable),
        .threshold  (threshold),
        .irq_ack    (irq_ack),
        .cnt_sync   (cnt_sync),
        .cnt_valid  (cnt_valid),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .irq        (irq),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: keeps the raw cnt_in value seen at each edge. The
    // synchronized value is the sample SYNC-1 edges old; a value is taken
    // once it has been seen on two consecutive synchronized samples.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] m_hist [0:SYNC];
    logic [WIDTH-1:0] m_cnt;
    logic             m_valid;
    logic             m_wrap;
    logic [7:0]       m_wcnt;
    logic             m_pend;
    logic             m_rel;
    logic             m_ovr;
    logic             m_hit_d;

    wire [WIDTH+11:0] obs_vec = {cnt_sync, cnt_valid, wrap_pulse, wrap_count, irq, overrun};
    wire [WIDTH+11:0] exp_vec = {m_cnt, m_valid, m_wrap, m_wcnt, m_pend, m_ovr};

    int               mis_cnt = 0;
    logic [WIDTH+11:0] first_obs;
    logic [WIDTH+11:0] first_exp;
    time              first_t;

    task automatic model_reset();
        for (int i = 0; i <= SYNC; i++) m_hist[i] = '0;
        m_cnt   = '0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
        m_wcnt  = 8'd0;
        m_pend  = 1'b0;
        m_rel   = 1'b0;
        m_ovr   = 1'b0;
        m_hit_d = 1'b0;
    endtask

    task automatic model_step();
        logic [WIDTH-1:0] sv;
        logic [WIDTH-1:0] sp;
        logic             acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // interrupt handshake reacts to the hit taken on the previous edge
        if (m_pend) begin
            if (m_hit_d) m_ovr = 1'b1;
            if (irq_ack) begin
                m_pend = 1'b0;
                m_rel  = 1'b1;
            end
        end else if (m_rel) begin
            if (m_hit_d) m_ovr = 1'b1;
            if (!irq_ack) m_rel = 1'b0;
        end else if (m_hit_d) begin
            m_pend = 1'b1;
        end
        sv      = m_hist[SYNC-1];
        sp      = m_hist[SYNC];
        acc     = enable && (sv == sp) && (sv != m_cnt);
        m_valid = acc;
        m_wrap  = acc && (sv < m_cnt);
        m_hit_d = acc && (sv == threshold);
        if (m_wrap && m_wcnt != 8'd255) m_wcnt = m_wcnt + 8'd1;
        if (acc) m_cnt = sv;
        for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = cnt_in;
    endtask

    // One clock: advance the model at the edge, compare at the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (obs_vec !== exp_vec) begin
            mis_cnt++;
            if (mis_cnt == 1) begin
                first_obs = obs_vec;
                first_exp = exp_vec;
                first_t   = $time;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        model_reset();
        cnt_in    = '0;
        enable    = 1'b1;
        irq_ack   = 1'b0;
        threshold = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic hold(input logic [WIDTH-1:0] v, input int n);
        cnt_in = v;
        repeat (n) tick();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic saw_valid;
        rst_n     = 1'b0;
        model_reset();
        cnt_in    = '0;
        enable    = 1'b1;
        irq_ack   = 1'b0;
        threshold = 4'd5;
        repeat (3) tick();
        checks++;
        if (obs_vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs_vec);
        end
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (10) begin
            tick();
            if (cnt_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_valid: got cnt_valid pulse, expected none");
        end
        checks++;
        if (obs_vec !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got %h expected 0", obs_vec);
        end
        checks++;
        if (mis_cnt !== 0) begin
            errors++;
            $display("FAIL reset_lockstep: %0d cycles differ, first at %0t got %h expected %h",
                     mis_cnt, first_t, first_obs, first_exp);
        end
        mis_cnt = 0;
    endtask

    task automatic test_steps();
        int lat;
        int nwrap;
        logic [WIDTH-1:0] v;
        do_reset();
        threshold = 4'd12;
        nwrap = 0;
        for (int s = 1; s <= 16; s++) begin
            v      = WIDTH'(s);
            cnt_in = v;
            lat    = 0;
            for (int k = 1; k <= 6; k++) begin
                tick();
                if (lat == 0 && cnt_valid && cnt_sync == v) lat = k;
                if (wrap_pulse) nwrap++;
            end
            checks++;
            if (lat !== SYNC + 2) begin
                errors++;
                $display("FAIL step_latency value %0d: got %0d edges expected %0d", v, lat, SYNC + 2);
            end
        end
        checks++;
        if (nwrap !== 1) begin
            errors++;
            $display("FAIL step_wrap_pulses: got %0d expected 1", nwrap);
        end
        checks++;
        if (wrap_count !== 8'd1) begin
            errors++;
            $display("FAIL step_wrap_count: got %0d expected 1", wrap_count);
        end
        checks++;
        if (mis_cnt !== 0) begin
            errors++;
            $display("FAIL steps_lockstep: %0d cycles differ, first at %0t got %h expected %h",
                     mis_cnt, first_t, first_obs, first_exp);
        end
        mis_cnt = 0;
    endtask

    task automatic test_glitch();
        logic saw5;
        int   n8;
        do_reset();
        threshold = 4'd0;
        hold(4'd7, 6);
        hold(4'd5, 1);
        cnt_in = 4'd8;
        saw5 = 1'b0;
        n8   = 0;
        repeat (8) begin
            tick();
            if (cnt_valid && cnt_sync == 4'd5) saw5 = 1'b1;
            if (cnt_valid && cnt_sync == 4'd8) n8++;
        end
        checks++;
        if (saw5 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_rejected: got a cnt_valid for 5, expected none");
        end
        checks++;
        if (n8 !== 1 || cnt_sync !== 4'd8) begin
            errors++;
            $display("FAIL glitch_accept8: got %0d pulses cnt_sync %0d expected 1 pulse cnt_sync 8", n8, cnt_sync);
        end
        checks++;
        if (mis_cnt !== 0) begin
            errors++;
            $display("FAIL glitch_lockstep: %0d cycles differ, first at %0t got %h expected %h",
                     mis_cnt, first_t, first_obs, first_exp);
        end
        mis_cnt = 0;
    endtask

    task automatic test_irq();
        logic found;
        do_reset();
        threshold = 4'd9;
        for (int v = 1; v <= 8; v++) hold(WIDTH'(v), 6);
        cnt_in = 4'd9;
        found  = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            if (cnt_valid && cnt_sync == 4'd9) found = 1'b1;
        end
        checks++;
        if (!found || irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_at_accept: got found=%0b irq=%0b expected found=1 irq=0", found, irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: got %0b expected 1", irq);
        end
        repeat (2) tick();
        irq_ack = 1'b1;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall_on_ack: got %0b expected 0", irq);
        end
        repeat (2) tick();
        irq_ack = 1'b0;
        repeat (2) tick();
        hold(4'd0, 6);
        hold(4'd9, 6);
        checks++;
        if (irq !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL irq_rearm: got irq=%0b overrun=%0b expected irq=1 overrun=0", irq, overrun);
        end
        checks++;
        if (mis_cnt !== 0) begin
            errors++;
            $display("FAIL irq_lockstep: %0d cycles differ, first at %0t got %h expected %h",
                     mis_cnt, first_t, first_obs, first_exp);
        end
        mis_cnt = 0;
    endtask

    task automatic test_overrun();
        do_reset();
        threshold = 4'd3;
        for (int v = 1; v <= 3; v++) hold(WIDTH'(v), 6);
        checks++;
        if (irq !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first_hit: got irq=%0b overrun=%0b expected irq=1 overrun=0", irq, overrun);
        end
        for (int v = 4; v <= 19; v++) hold(WIDTH'(v % 16), 6);
        checks++;
        if (irq !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second_hit: got irq=%0b overrun=%0b expected irq=1 overrun=1", irq, overrun);
        end
        irq_ack = 1'b1;
        repeat (2) tick();
        irq_ack = 1'b0;
        repeat (2) tick();
        checks++;
        if (irq !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got irq=%0b overrun=%0b expected irq=0 overrun=1", irq, overrun);
        end
        checks++;
        if (mis_cnt !== 0) begin
            errors++;
            $display("FAIL ovr_lockstep: %0d cycles differ, first at %0t got %h expected %h",
                     mis_cnt, first_t, first_obs, first_exp);
        end
        mis_cnt = 0;
    endtask

    task automatic test_wrap_saturate();
        logic found;
        int   lat;
        do_reset();
        threshold = 4'd5;
        for (int n = 0; n < 300; n++) begin
            hold(4'd15, 3);
            hold(4'd0, 3);
        end
        checks++;
        if (wrap_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_saturate: got %0d expected 255", wrap_count);
        end
        hold(4'd15, 3);
        cnt_in = 4'd6;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec !== '0) begin
            errors++;
            $display("FAIL async_reset_clear: got %h expected 0", obs_vec);
        end
        tick();
        rst_n = 1'b1;
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 8 && !found; k++) begin
            tick();
            if (cnt_valid && cnt_sync == 4'd6) begin
                found = 1'b1;
                lat   = k;
            end
        end
        checks++;
        if (lat !== SYNC + 2) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d edges expected %0d", lat, SYNC + 2);
        end
        checks++;
        if (mis_cnt !== 0) begin
            errors++;
            $display("FAIL wrap_lockstep: %0d cycles differ, first at %0t got %h expected %h",
                     mis_cnt, first_t, first_obs, first_exp);
        end
        mis_cnt = 0;
    endtask

    task automatic test_random();
        int nvalid;
        do_reset();
        threshold = WIDTH'($urandom_range(0, 15));
        nvalid = 0;
        for (int seg = 0; seg < 600; seg++) begin
            cnt_in = WIDTH'($urandom_range(0, 15));
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) irq_ack = ~irq_ack;
            if ($urandom_range(0, 9) == 0) threshold = WIDTH'($urandom_range(0, 15));
            repeat ($urandom_range(1, 5)) begin
                tick();
                if (cnt_valid) nvalid++;
            end
        end
        checks++;
        if (nvalid == 0) begin
            errors++;
            $display("FAIL random_activity: got 0 accepted values expected some");
        end
        checks++;
        if (mis_cnt !== 0) begin
            errors++;
            $display("FAIL random_lockstep: %0d cycles differ, first at %0t got %h expected %h",
                     mis_cnt, first_t, first_obs, first_exp);
        end
        mis_cnt = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cnt_in    = '0;
        enable    = 1'b1;
        threshold = '0;
        irq_ack   = 1'b0;
        model_reset();
        test_reset();
        test_steps();
        test_glitch();
        test_irq();
        test_overrun();
        test_wrap_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_count_monitor
`default_nettype wire
